// File: rtl/ip_pkg.sv
// Shared IPv4 receive definitions: parser states, header field record and protocol constants.
// No logic; latency and backpressure are properties of the modules that import this package.
// Header byte counts are 16 bits wide so they compare directly against total_len.
package ip_pkg;

  typedef enum logic [2:0] {SYNC, IDLE, HDR, PAYLOAD, DROP} ip_state_t;

  localparam logic [3:0]  IP_VERSION4      = 4'd4;
  localparam logic [15:0] IP_HDR_MIN_BYTES = 16'd20;
  localparam logic [7:0]  IP_PROTO_ICMP    = 8'd1;
  localparam logic [7:0]  IP_PROTO_UDP     = 8'd17;
  localparam logic [31:0] IP_BCAST         = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [3:0]  ihl;
    logic [15:0] total_len;
    logic        mf;
    logic [12:0] frag_off;
    logic [7:0]  proto;
    logic [31:0] src;
    logic [31:0] dst;
  } hdr_t;

  function automatic logic [15:0] hdr_bytes(input logic [3:0] ihl);
    return {10'd0, ihl, 2'b00};
  endfunction

endpackage

// File: rtl/ip_hdr_csum.sv
// Byte-serial ones-complement header sum; even bytes are held, odd bytes complete a word.
// Latency: o_sum already includes the byte presented this cycle (combinational look-ahead).
// Backpressure: none; bytes are consumed only when i_vld is high.
module ip_hdr_csum (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_vld,
  input  logic        i_odd,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_sum
);

  logic [15:0] sum_q;
  logic [15:0] base;
  logic [16:0] add;
  logic [7:0]  hi_q;

  // A clear on the same cycle as a byte restarts the sum from that byte.
  always_comb begin
    base  = i_clr ? 16'd0 : sum_q;
    add   = {1'b0, base} + {1'b0, hi_q, i_byte};
    o_sum = base;
    if (i_vld && i_odd)
      o_sum = add[15:0] + {15'd0, add[16]};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sum_q <= 16'd0;
      hi_q  <= 8'd0;
    end else begin
      sum_q <= o_sum;
      if (i_vld && !i_odd)
        hi_q <= i_byte;
    end
  end

endmodule

// File: rtl/ip_rx_mux.sv
// IPv4 RX parser: validates header, forwards payload with one-hot channel select. IP_RX_BCAST_EN adds broadcast accept.
// Latency: payload byte appears on o_data/o_valid one cycle after it is accepted on i_mac_data.
// Backpressure: none; input is consumed whenever i_mac_valid is high, gaps in i_mac_valid just stall parsing.
module ip_rx_mux
  import ip_pkg::*;
#(
  parameter logic [31:0]             P_LOCAL_IP   = {8'd192, 8'd168, 8'd1, 8'd1},
  parameter int                      P_CHAN_NUM   = 2,
  parameter logic [8*P_CHAN_NUM-1:0] P_PROTO_LIST = {IP_PROTO_ICMP, IP_PROTO_UDP},
  parameter int                      P_CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [31:0]           i_local_ip,
  input  logic                  i_local_ip_valid,
  input  logic [7:0]            i_mac_data,
  input  logic                  i_mac_valid,
  input  logic                  i_mac_last,
  output logic [7:0]            o_data,
  output logic [15:0]           o_len,
  output logic                  o_last,
  output logic                  o_valid,
  output logic [P_CHAN_NUM-1:0] o_chan,
  output logic                  o_err,
  output logic [31:0]           o_recv_src_ip,
  output logic                  o_recv_src_valid,
  output logic [P_CNT_W-1:0]    o_drop_cnt
);

  ip_state_t             state_q, state_d;
  hdr_t                  hdr_q;
  logic [15:0]           cnt_q;
  logic [15:0]           hdr_end;
  logic [15:0]           csum_sum;
  logic [31:0]           local_ip_q;
  logic [31:0]           dst_now;
  logic [P_CHAN_NUM-1:0] chan_hit;
  logic                  byte0_bad, dst_ok, hdr_ok, pay_end, pay_vld;
  logic                  drop_inc, accept;

  ip_hdr_csum u_csum (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (state_q != HDR),
    .i_vld  (i_mac_valid && (state_q == IDLE || state_q == HDR)),
    .i_odd  (state_q == HDR && cnt_q[0]),
    .i_byte (i_mac_data),
    .o_sum  (csum_sum)
  );

  // With a 20-byte header the last destination octet is the decision byte itself.
  assign dst_now   = (hdr_q.ihl == 4'd5) ? {hdr_q.dst[31:8], i_mac_data} : hdr_q.dst;
  assign hdr_end   = hdr_bytes(hdr_q.ihl) - 16'd1;
  assign byte0_bad = (i_mac_data[7:4] != IP_VERSION4) || (hdr_bytes(i_mac_data[3:0]) < IP_HDR_MIN_BYTES);
  assign pay_vld   = i_mac_valid && (state_q == PAYLOAD);
  assign pay_end   = (cnt_q == o_len - 16'd1);

`ifdef IP_RX_BCAST_EN
  assign dst_ok = (dst_now == local_ip_q) || (dst_now == IP_BCAST) ||
                  (dst_now == {local_ip_q[31:8], 8'hFF});
`else
  assign dst_ok = (dst_now == local_ip_q);
`endif

  // Descending scan so the lowest matching table index wins.
  always_comb begin
    chan_hit = '0;
    for (int i = P_CHAN_NUM - 1; i >= 0; i--) begin
      if (P_PROTO_LIST[8*i +: 8] == hdr_q.proto) begin
        chan_hit    = '0;
        chan_hit[i] = 1'b1;
      end
    end
  end

  assign hdr_ok = (csum_sum == 16'hFFFF) && !hdr_q.mf && (hdr_q.frag_off == 13'd0) &&
                  dst_ok && (|chan_hit) && (hdr_q.total_len > hdr_bytes(hdr_q.ihl));

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= SYNC;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    drop_inc = 1'b0;
    accept   = 1'b0;
    case (state_q)
      SYNC:    if (!i_mac_valid) state_d = IDLE;
      IDLE:
        if (i_mac_valid) begin
          if (byte0_bad || i_mac_last) begin
            drop_inc = 1'b1;
            state_d  = i_mac_last ? IDLE : DROP;
          end else begin
            state_d = HDR;
          end
        end
      HDR:
        if (i_mac_valid) begin
          if (i_mac_last) begin
            drop_inc = 1'b1;
            state_d  = IDLE;
          end else if (cnt_q == hdr_end) begin
            accept   = hdr_ok;
            drop_inc = !hdr_ok;
            state_d  = hdr_ok ? PAYLOAD : DROP;
          end
        end
      PAYLOAD:
        if (i_mac_valid) begin
          if (i_mac_last)   state_d = IDLE;
          else if (pay_end) state_d = DROP;
        end
      DROP:    if (i_mac_valid && i_mac_last) state_d = IDLE;
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q            <= 16'd0;
      hdr_q            <= '0;
      local_ip_q       <= P_LOCAL_IP;
      o_data           <= 8'd0;
      o_len            <= 16'd0;
      o_last           <= 1'b0;
      o_valid          <= 1'b0;
      o_chan           <= '0;
      o_err            <= 1'b0;
      o_recv_src_ip    <= 32'd0;
      o_recv_src_valid <= 1'b0;
      o_drop_cnt       <= '0;
    end else begin
      if (i_local_ip_valid)
        local_ip_q <= i_local_ip;
      if (drop_inc && (o_drop_cnt != '1))
        o_drop_cnt <= o_drop_cnt + {{(P_CNT_W-1){1'b0}}, 1'b1};

      o_valid          <= pay_vld;
      o_last           <= pay_vld && (pay_end || i_mac_last);
      o_err            <= pay_vld && i_mac_last && !pay_end;
      o_recv_src_valid <= pay_vld && (cnt_q == 16'd0);
      if (pay_vld)
        o_data <= i_mac_data;

      if (accept) begin
        o_chan        <= chan_hit;
        o_len         <= hdr_q.total_len - hdr_bytes(hdr_q.ihl);
        o_recv_src_ip <= hdr_q.src;
      end

      if (i_mac_valid) begin
        case (state_q)
          IDLE: begin
            cnt_q     <= 16'd1;
            hdr_q.ihl <= i_mac_data[3:0];
          end
          HDR: begin
            cnt_q <= (cnt_q == hdr_end) ? 16'd0 : cnt_q + 16'd1;
            case (cnt_q)
              16'd2:  hdr_q.total_len[15:8] <= i_mac_data;
              16'd3:  hdr_q.total_len[7:0]  <= i_mac_data;
              16'd6: begin
                hdr_q.mf             <= i_mac_data[5];
                hdr_q.frag_off[12:8] <= i_mac_data[4:0];
              end
              16'd7:  hdr_q.frag_off[7:0] <= i_mac_data;
              16'd9:  hdr_q.proto         <= i_mac_data;
              16'd12: hdr_q.src[31:24]    <= i_mac_data;
              16'd13: hdr_q.src[23:16]    <= i_mac_data;
              16'd14: hdr_q.src[15:8]     <= i_mac_data;
              16'd15: hdr_q.src[7:0]      <= i_mac_data;
              16'd16: hdr_q.dst[31:24]    <= i_mac_data;
              16'd17: hdr_q.dst[23:16]    <= i_mac_data;
              16'd18: hdr_q.dst[15:8]     <= i_mac_data;
              16'd19: hdr_q.dst[7:0]      <= i_mac_data;
              default: ;
            endcase
          end
          PAYLOAD: cnt_q <= cnt_q + 16'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ip_rx_mux.sv
// Directed bench for ip_rx_mux: table of packet records plus hand sequences for truncation, reset and local IP reload.
// Channel table here is ch0 = ICMP, ch1 = UDP.
module tb_ip_rx_mux;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_local_ip;
  logic        i_local_ip_valid;
  logic [7:0]  i_mac_data;
  logic        i_mac_valid;
  logic        i_mac_last;
  logic [7:0]  o_data;
  logic [15:0] o_len;
  logic        o_last;
  logic        o_valid;
  logic [1:0]  o_chan;
  logic        o_err;
  logic [31:0] o_recv_src_ip;
  logic        o_recv_src_valid;
  logic [15:0] o_drop_cnt;

  always #5 i_clk = ~i_clk;

  ip_rx_mux #(
    .P_LOCAL_IP   (32'hC0A8_0101),
    .P_CHAN_NUM   (2),
    .P_PROTO_LIST ({8'd17, 8'd1}),
    .P_CNT_W      (16)
  ) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_local_ip       (i_local_ip),
    .i_local_ip_valid (i_local_ip_valid),
    .i_mac_data       (i_mac_data),
    .i_mac_valid      (i_mac_valid),
    .i_mac_last       (i_mac_last),
    .o_data           (o_data),
    .o_len            (o_len),
    .o_last           (o_last),
    .o_valid          (o_valid),
    .o_chan           (o_chan),
    .o_err            (o_err),
    .o_recv_src_ip    (o_recv_src_ip),
    .o_recv_src_valid (o_recv_src_valid),
    .o_drop_cnt       (o_drop_cnt)
  );

`ifdef IP_RX_BCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif
  localparam logic [31:0] SRC_IP = 32'h0A01_0203;

  typedef struct {
    logic [3:0]  ver;
    logic [3:0]  ihl;
    logic [7:0]  proto;
    logic        mf;
    logic [12:0] foff;
    logic [31:0] dst;
    int          plen;
    int          pad;
    bit          bad;
    int          gap;
    bit          acc;
    logic [1:0]  chan;
  } vec_t;

  vec_t        vecs [13];
  vec_t        v;
  logic [7:0]  frame [$];
  logic [7:0]  rx_q [$];
  int          n_chk, n_fail;
  int          last_idx, last_cnt, err_cnt, src_cnt;
  logic [31:0] src_seen;
  logic [15:0] exp_drop, exp_len;
  logic [1:0]  exp_chan;

  always @(negedge i_clk) begin
    if (o_valid) begin
      rx_q.push_back(o_data);
      if (o_last) begin
        last_idx = rx_q.size() - 1;
        last_cnt++;
      end
    end
    if (o_err) err_cnt++;
    if (o_recv_src_valid) begin
      src_cnt++;
      src_seen = o_recv_src_ip;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_mon();
    rx_q.delete();
    last_idx = -1;
    last_cnt = 0;
    err_cnt  = 0;
    src_cnt  = 0;
    src_seen = 32'd0;
  endtask

  // cut >= 0 truncates the frame after that many payload bytes, with no padding.
  task automatic build_frame(input vec_t pv, input logic [7:0] base, input int cut);
    int          hb, n;
    logic [15:0] tl;
    logic [31:0] sum;
    hb = ((pv.ihl < 4'd5) ? 5 : int'(pv.ihl)) * 4;
    tl = 16'(hb + pv.plen);
    frame.delete();
    for (int j = 0; j < hb; j++) frame.push_back(8'(j * 7));
    frame[0]  = {pv.ver, pv.ihl};
    frame[1]  = 8'h00;
    frame[2]  = tl[15:8];
    frame[3]  = tl[7:0];
    frame[4]  = 8'h12;
    frame[5]  = 8'h34;
    frame[6]  = {2'b00, pv.mf, pv.foff[12:8]};
    frame[7]  = pv.foff[7:0];
    frame[8]  = 8'h40;
    frame[9]  = pv.proto;
    frame[10] = 8'h00;
    frame[11] = 8'h00;
    for (int j = 0; j < 4; j++) begin
      frame[12+j] = SRC_IP[31-8*j -: 8];
      frame[16+j] = pv.dst[31-8*j -: 8];
    end
    sum = 32'd0;
    for (int j = 0; j < hb; j += 2) sum += {16'd0, frame[j], frame[j+1]};
    while (sum[31:16] != 16'd0) sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
    frame[10] = ~sum[15:8];
    frame[11] = ~sum[7:0];
    if (pv.bad) frame[11] = frame[11] ^ 8'h01;
    n = (cut >= 0) ? cut : pv.plen;
    for (int k = 0; k < n; k++) frame.push_back(8'(base + k));
    if (cut < 0)
      for (int k = 0; k < pv.pad; k++) frame.push_back(8'h00);
  endtask

  task automatic drive_frame(input int gap);
    for (int i = 0; i < frame.size(); i++) begin
      if (gap > 0 && i > 0 && (i % gap) == 0) begin
        @(posedge i_clk); #1;
        i_mac_valid = 1'b0;
        i_mac_last  = 1'b0;
      end
      @(posedge i_clk); #1;
      i_mac_data  = frame[i];
      i_mac_valid = 1'b1;
      i_mac_last  = (i == frame.size() - 1);
    end
    @(posedge i_clk); #1;
    i_mac_valid = 1'b0;
    i_mac_last  = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
  endtask

  task automatic run_vec(input vec_t pv, input int idx, input int cut);
    logic [7:0] base;
    int         n_exp;
    base = 8'(idx * 16);
    reset_mon();
    build_frame(pv, base, cut);
    drive_frame(pv.gap);
    n_exp = 0;
    if (pv.acc) begin
      n_exp    = (cut >= 0) ? cut : pv.plen;
      exp_chan = pv.chan;
      exp_len  = 16'(pv.plen);
    end else begin
      exp_drop = exp_drop + 16'd1;
    end
    chk($sformatf("v%0d rx_count", idx), rx_q.size(), n_exp);
    for (int k = 0; k < rx_q.size() && k < n_exp; k++)
      chk($sformatf("v%0d data[%0d]", idx, k), {24'd0, rx_q[k]}, {24'd0, 8'(base + k)});
    chk($sformatf("v%0d last_cnt", idx), last_cnt, pv.acc ? 1 : 0);
    chk($sformatf("v%0d last_idx", idx), last_idx, pv.acc ? n_exp - 1 : -1);
    chk($sformatf("v%0d err_cnt", idx), err_cnt, (pv.acc && cut >= 0) ? 1 : 0);
    chk($sformatf("v%0d src_cnt", idx), src_cnt, pv.acc ? 1 : 0);
    if (pv.acc) chk($sformatf("v%0d src_ip", idx), src_seen, SRC_IP);
    chk($sformatf("v%0d o_chan", idx), {30'd0, o_chan}, {30'd0, exp_chan});
    chk($sformatf("v%0d o_len", idx), {16'd0, o_len}, {16'd0, exp_len});
    chk($sformatf("v%0d drop_cnt", idx), {16'd0, o_drop_cnt}, {16'd0, exp_drop});
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    exp_drop = 16'd0;
    exp_len  = 16'd0;
    exp_chan = 2'b00;
    reset_mon();
    //            ver   ihl   proto  mf    foff   dst            plen pad bad gap acc chan
    vecs[0]  = '{4'd4, 4'd5, 8'd17, 1'b0, 13'd0, 32'hC0A80101, 8,   0,  0,  0,  1,  2'b10};
    vecs[1]  = '{4'd4, 4'd5, 8'd17, 1'b0, 13'd0, 32'hC0A80101, 8,   0,  1,  0,  0,  2'b00};
    vecs[2]  = '{4'd4, 4'd5, 8'd17, 1'b0, 13'd0, 32'hC0A80101, 8,   0,  0,  3,  1,  2'b10};
    vecs[3]  = '{4'd4, 4'd6, 8'd1,  1'b0, 13'd0, 32'hC0A80101, 4,   18, 0,  0,  1,  2'b01};
    vecs[4]  = '{4'd4, 4'd5, 8'd17, 1'b1, 13'd0, 32'hC0A80101, 8,   0,  0,  0,  0,  2'b00};
    vecs[5]  = '{4'd4, 4'd5, 8'd17, 1'b0, 13'd0, 32'hC0A80109, 8,   0,  0,  0,  0,  2'b00};
    vecs[6]  = '{4'd4, 4'd5, 8'd6,  1'b0, 13'd0, 32'hC0A80101, 8,   0,  0,  0,  0,  2'b00};
    vecs[7]  = '{4'd4, 4'd5, 8'd17, 1'b0, 13'd1, 32'hC0A80101, 8,   0,  0,  0,  0,  2'b00};
    vecs[8]  = '{4'd6, 4'd5, 8'd17, 1'b0, 13'd0, 32'hC0A80101, 8,   0,  0,  0,  0,  2'b00};
    vecs[9]  = '{4'd4, 4'd4, 8'd17, 1'b0, 13'd0, 32'hC0A80101, 8,   0,  0,  0,  0,  2'b00};
    vecs[10] = '{4'd4, 4'd5, 8'd17, 1'b0, 13'd0, 32'hC0A80101, 0,   6,  0,  0,  0,  2'b00};
    vecs[11] = '{4'd4, 4'd7, 8'd17, 1'b0, 13'd0, 32'hC0A80101, 3,   10, 0,  2,  1,  2'b10};
    vecs[12] = '{4'd4, 4'd5, 8'd1,  1'b0, 13'd0, 32'hC0A80101, 1,   5,  0,  0,  1,  2'b01};

    i_rst            = 1'b1;
    i_local_ip       = 32'd0;
    i_local_ip_valid = 1'b0;
    i_mac_data       = 8'd0;
    i_mac_valid      = 1'b0;
    i_mac_last       = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset o_valid", {31'd0, o_valid}, 32'd0);
    chk("reset o_data", {24'd0, o_data}, 32'd0);
    chk("reset o_last", {31'd0, o_last}, 32'd0);
    chk("reset o_err", {31'd0, o_err}, 32'd0);
    chk("reset o_chan", {30'd0, o_chan}, 32'd0);
    chk("reset o_len", {16'd0, o_len}, 32'd0);
    chk("reset o_src_ip", o_recv_src_ip, 32'd0);
    chk("reset o_src_valid", {31'd0, o_recv_src_valid}, 32'd0);
    chk("reset o_drop_cnt", {16'd0, o_drop_cnt}, 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i, -1);

    // total_len 40 but frame ends after 5 payload bytes, then a normal frame
    v = vecs[0];
    v.plen = 20;
    run_vec(v, 13, 5);
    run_vec(vecs[0], 14, -1);

    // reset during payload with i_mac_valid held high through the rest of the frame
    build_frame(vecs[0], 8'h30, -1);
    for (int i = 0; i < frame.size() + 30; i++) begin
      @(posedge i_clk); #1;
      i_mac_data  = (i < frame.size()) ? frame[i] : 8'h45;
      i_mac_valid = 1'b1;
      i_mac_last  = (i == frame.size() + 29);
      i_rst       = (i == 24);
      if (i == 25) begin
        @(negedge i_clk);
        chk("midrst o_valid", {31'd0, o_valid}, 32'd0);
        chk("midrst o_chan", {30'd0, o_chan}, 32'd0);
        chk("midrst o_len", {16'd0, o_len}, 32'd0);
        chk("midrst o_drop_cnt", {16'd0, o_drop_cnt}, 32'd0);
        chk("midrst o_src_ip", o_recv_src_ip, 32'd0);
        reset_mon();
      end
    end
    @(posedge i_clk); #1;
    i_mac_valid = 1'b0;
    i_mac_last  = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    exp_drop = 16'd0;
    exp_chan = 2'b00;
    exp_len  = 16'd0;
    chk("postrst rx_count", rx_q.size(), 0);
    chk("postrst drop_cnt", {16'd0, o_drop_cnt}, 32'd0);
    chk("postrst src_cnt", src_cnt, 0);

    @(posedge i_clk); #1;
    i_local_ip       = 32'h0A00_0005;
    i_local_ip_valid = 1'b1;
    @(posedge i_clk); #1;
    i_local_ip_valid = 1'b0;

    v = vecs[0];
    v.dst = 32'h0A00_0005;
    run_vec(v, 15, -1);
    v.dst = 32'hC0A8_0101;
    v.acc = 1'b0;
    run_vec(v, 16, -1);
    v = vecs[0];
    v.dst = IP_BCAST_TB();
    v.acc = BCAST;
    run_vec(v, 17, -1);
    v = vecs[12];
    v.dst = 32'h0A00_00FF;
    v.acc = BCAST;
    run_vec(v, 18, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  function automatic logic [31:0] IP_BCAST_TB();
    return 32'hFFFF_FFFF;
  endfunction

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
